radar_pulse_sequencer: RTL and testbench
========================================

# radar_pulse_sequencer

Pulse-repetition scheduler for the radar DAC/ADC loopback experiment. On each pulse repetition interval (PRI) it opens a transmit window that steps the DAC waveform address, then a receive window that indexes ADC samples, and optionally puts the DAC to sleep between pulses. It sits between the host/config registers and the waveform ROM, DAC driver and ADC capture logic, all on the 10 MHz system clock.

## Interface
- CNT_W, 16, width of PRI/timing counters and config words
- ADDR_W, 10, waveform ROM address width
- WAKE, 8, DAC sleep-exit lead time in clocks (used only with DAC_SLEEP_EN)

- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin pulsing
- stop  in  1  one-cycle request to end after current PRI
- pri  in  CNT_W  PRI length in clocks
- pw  in  CNT_W  transmit pulse width in clocks
- rx_dly  in  CNT_W  receive window start offset from PRI start
- rx_len  in  CNT_W  receive window length in clocks
- busy  out  1  high while not IDLE
- pulse_sof  out  1  one-cycle strobe at t==0 of each PRI
- tx_en  out  1  DAC waveform valid
- wave_addr  out  ADDR_W  waveform ROM address
- rx_en  out  1  ADC capture window
- rx_idx  out  CNT_W  sample index inside receive window
- pulse_cnt  out  16  pulses issued since last start
- cfg_err  out  1  sticky: rejected configuration
- sleep_dac  out  1  DAC sleep control

## Operation
- States: IDLE, WAKEUP (macro only), RUN.
- Config valid iff pri>=2, 1<=pw<=pri, rx_len>=1, rx_dly+rx_len<=pri (compare at CNT_W+1 bits, no overflow).
- IDLE: start with valid config -> RUN (or WAKEUP); config latched into shadow regs, pulse_cnt cleared, cfg_err cleared. Start with invalid config -> stay IDLE, cfg_err=1.
- RUN: PRI counter t counts 0..pri_s-1, wraps to 0.
  - tx_en = (t < pw_s); wave_addr = t[ADDR_W-1:0] while tx_en, else 0 (wraps silently if pw > 2^ADDR_W).
  - rx_en = (rx_dly_s <= t < rx_dly_s+rx_len_s); rx_idx = t-rx_dly_s while rx_en, else 0.
  - pulse_sof at t==0; pulse_cnt +1 on each sof, saturates at 16'hFFFF.
- Config re-sampled and re-validated at every wrap (t==pri_s-1 -> 0); invalid -> IDLE, cfg_err=1, no sof.
- stop sets stop_pend; at t==pri_s-1 with stop_pend -> IDLE. Stop in IDLE ignored.
- start while busy ignored. start and stop in same IDLE cycle: stop wins, stay IDLE.
- Receive window may overlap transmit window; both asserted independently.

## Timing
- Reset: busy=0, pulse_sof=0, tx_en=0, wave_addr=0, rx_en=0, rx_idx=0, pulse_cnt=0, cfg_err=0, sleep_dac=0 (1 with macro). Internal state IDLE, stop_pend=0.
- All outputs registered. Without macro: start sampled in cycle N -> pulse_sof, tx_en, busy high in N+1 (t=0).
- Last PRI: final cycle t=pri_s-1; in next cycle all window outputs 0, busy=0.
- Reset mid-run: outputs to reset values immediately (async), no completion of PRI.

## Configuration
- DAC_SLEEP_EN defined:
  - sleep_dac=1 in IDLE and in RUN when t>=pw_s and (pri_s-1-t)>=WAKE; 0 otherwise (during TX and final WAKE cycles of each PRI).
  - start -> WAKEUP for WAKE cycles with sleep_dac=0, busy=1; then RUN, t=0. First sof at N+1+WAKE.
  - stop or invalid config during WAKEUP -> IDLE at end of WAKEUP, no pulse.
- DAC_SLEEP_EN undefined: sleep_dac constant 0, no WAKEUP state, WAKE unused.

## Test plan
- pri=20, pw=5, rx_dly=8, rx_len=6, start pulse -> sof every 20 clks; tx_en t=0..4 with wave_addr 0..4; rx_en t=8..13 with rx_idx 0..5.
- pw=0 or rx_dly=15,rx_len=6 with pri=20, start -> busy stays 0, cfg_err=1; next valid start clears cfg_err and runs.
- Running, stop asserted at t=7 -> PRI completes to t=19, busy=0 next cycle, pulse_cnt equals sofs issued; start/stop together in IDLE -> no activity.
- Mid-run change pri 20->10 at t=3 -> current PRI still 20 clks, following PRIs 10 clks; change to invalid -> IDLE at wrap, cfg_err=1.
- rst_n low at t=2 of TX -> all outputs reset values same cycle; after release no activity until start.
- DAC_SLEEP_EN, WAKE=8, pri=40, pw=5 -> sof at start+9; sleep_dac=1 for t=5..31, 0 for t=32..39 and t=0..4; 1 in IDLE.

Source files
------------

// File: rtl/radar_pulse_sequencer.sv
// radar_pulse_sequencer: PRI scheduler for the DAC/ADC loopback.
// Optional DAC sleep with wake lead time: define DAC_SLEEP_EN.
`timescale 1ns/1ps
module radar_pulse_sequencer #(
   parameter int CNT_W  = 16,
   parameter int ADDR_W = 10,
   parameter int WAKE   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic [CNT_W-1:0]  pri,
   input  logic [CNT_W-1:0]  pw,
   input  logic [CNT_W-1:0]  rx_dly,
   input  logic [CNT_W-1:0]  rx_len,
   output logic              busy,
   output logic              pulse_sof,
   output logic              tx_en,
   output logic [ADDR_W-1:0] wave_addr,
   output logic              rx_en,
   output logic [CNT_W-1:0]  rx_idx,
   output logic [15:0]       pulse_cnt,
   output logic              cfg_err,
   output logic              sleep_dac
);

`ifdef DAC_SLEEP_EN
   localparam logic SLEEP_ON = 1'b1;
   localparam int   WK_W     = $clog2(WAKE + 1);
   typedef enum logic [1:0] {IDLE = 2'd0, WAKEUP = 2'd1, RUN = 2'd2} state_t;
   logic [WK_W-1:0] w_q, w_n;
`else
   localparam logic SLEEP_ON = 1'b0;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd2} state_t;
`endif

   state_t           state_q, state_n;
   logic [CNT_W-1:0] t_q, t_n;
   logic [CNT_W-1:0] pri_s, pw_s, dly_s, len_s;
   logic [CNT_W-1:0] pri_n, pw_n, dly_n, len_n;
   logic             stop_q, stop_n;
   logic             err_q, err_n;
   logic [15:0]      cnt_q, cnt_n;
   logic             sof_n;
   logic             cfg_ok, last, sp;

   // Configuration check with one spare bit so rx_dly+rx_len cannot wrap.
   always_comb begin
      cfg_ok = ({1'b0, pri} >= (CNT_W+1)'(2))
             && (pw != '0)
             && (pw <= pri)
             && (rx_len != '0)
             && (({1'b0, rx_dly} + {1'b0, rx_len}) <= {1'b0, pri});
   end

   // Next-state logic: idle/wakeup/run sequencing and per-PRI re-latching.
   always_comb begin
      state_n = state_q;
      t_n     = t_q;
      pri_n   = pri_s;
      pw_n    = pw_s;
      dly_n   = dly_s;
      len_n   = len_s;
      stop_n  = stop_q;
      err_n   = err_q;
      cnt_n   = cnt_q;
      sof_n   = 1'b0;
`ifdef DAC_SLEEP_EN
      w_n     = w_q;
`endif
      sp      = stop_q | stop;
      last    = (t_q == pri_s - CNT_W'(1));
      unique case (state_q)
         IDLE: begin
            if (start && !stop) begin
               if (cfg_ok) begin
                  pri_n  = pri;
                  pw_n   = pw;
                  dly_n  = rx_dly;
                  len_n  = rx_len;
                  cnt_n  = '0;
                  err_n  = 1'b0;
                  stop_n = 1'b0;
                  t_n    = '0;
`ifdef DAC_SLEEP_EN
                  state_n = WAKEUP;
                  w_n     = '0;
`else
                  state_n = RUN;
                  sof_n   = 1'b1;
`endif
               end else begin
                  err_n = 1'b1;
               end
            end
         end
`ifdef DAC_SLEEP_EN
         WAKEUP: begin
            if (w_q == WK_W'(WAKE - 1)) begin
               stop_n = 1'b0;
               if (sp) begin
                  state_n = IDLE;
               end else if (cfg_ok) begin
                  pri_n   = pri;
                  pw_n    = pw;
                  dly_n   = rx_dly;
                  len_n   = rx_len;
                  state_n = RUN;
                  t_n     = '0;
                  sof_n   = 1'b1;
               end else begin
                  state_n = IDLE;
                  err_n   = 1'b1;
               end
            end else begin
               w_n    = w_q + WK_W'(1);
               stop_n = sp;
            end
         end
`endif
         RUN: begin
            if (last) begin
               stop_n = 1'b0;
               if (sp) begin
                  state_n = IDLE;
               end else if (cfg_ok) begin
                  pri_n = pri;
                  pw_n  = pw;
                  dly_n = rx_dly;
                  len_n = rx_len;
                  t_n   = '0;
                  sof_n = 1'b1;
               end else begin
                  state_n = IDLE;
                  err_n   = 1'b1;
               end
            end else begin
               t_n    = t_q + CNT_W'(1);
               stop_n = sp;
            end
         end
         default: state_n = IDLE;
      endcase
      if (sof_n && (cnt_n != 16'hFFFF))
         cnt_n = cnt_n + 16'd1;
   end

   // Control state and shadow configuration registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         t_q     <= '0;
         pri_s   <= '0;
         pw_s    <= '0;
         dly_s   <= '0;
         len_s   <= '0;
         stop_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
`ifdef DAC_SLEEP_EN
         w_q     <= '0;
`endif
      end else begin
         state_q <= state_n;
         t_q     <= t_n;
         pri_s   <= pri_n;
         pw_s    <= pw_n;
         dly_s   <= dly_n;
         len_s   <= len_n;
         stop_q  <= stop_n;
         err_q   <= err_n;
         cnt_q   <= cnt_n;
`ifdef DAC_SLEEP_EN
         w_q     <= w_n;
`endif
      end
   end

   logic             run_n, tx_n, rx_n, sleep_n;
   logic [CNT_W:0]   lead;

   // Window decode from the upcoming state so every output is a flop.
   always_comb begin
      run_n = (state_n == RUN);
      tx_n  = run_n && (t_n < pw_n);
      rx_n  = run_n
            && ({1'b0, t_n} >= {1'b0, dly_n})
            && ({1'b0, t_n} < ({1'b0, dly_n} + {1'b0, len_n}));
      lead  = {1'b0, pri_n} - {1'b0, t_n} - (CNT_W+1)'(1);
      sleep_n = SLEEP_ON
              & ((state_n == IDLE)
              | (run_n && (t_n >= pw_n) && (lead >= (CNT_W+1)'(WAKE))));
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy      <= 1'b0;
         pulse_sof <= 1'b0;
         tx_en     <= 1'b0;
         wave_addr <= '0;
         rx_en     <= 1'b0;
         rx_idx    <= '0;
         sleep_dac <= SLEEP_ON;
      end else begin
         busy      <= (state_n != IDLE);
         pulse_sof <= sof_n;
         tx_en     <= tx_n;
         wave_addr <= tx_n ? t_n[ADDR_W-1:0] : '0;
         rx_en     <= rx_n;
         rx_idx    <= rx_n ? (t_n - dly_n) : '0;
         sleep_dac <= sleep_n;
      end
   end

   assign pulse_cnt = cnt_q;
   assign cfg_err   = err_q;

endmodule

// File: tb/tb_radar_pulse_sequencer.sv
// tb_radar_pulse_sequencer: directed plus random stimulus against a
// cycle-level reference model of the PRI schedule.
`timescale 1ns/1ps
module tb_radar_pulse_sequencer;
   localparam int CNT_W  = 16;
   localparam int ADDR_W = 10;
   localparam int WAKE   = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic [CNT_W-1:0]  pri = 16'd20;
   logic [CNT_W-1:0]  pw = 16'd5;
   logic [CNT_W-1:0]  rx_dly = 16'd8;
   logic [CNT_W-1:0]  rx_len = 16'd6;
   logic              busy, pulse_sof, tx_en, rx_en, cfg_err, sleep_dac;
   logic [ADDR_W-1:0] wave_addr;
   logic [CNT_W-1:0]  rx_idx;
   logic [15:0]       pulse_cnt;

   int checks = 0;
   int errors = 0;

   // model: ph 0=idle 1=waking 2=pulsing
   int ph, mt, mw, mp, mpw, md, ml, mcnt;
   bit msp, merr;

   always #50 clk = ~clk;

   radar_pulse_sequencer #(
      .CNT_W(CNT_W), .ADDR_W(ADDR_W), .WAKE(WAKE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .pri(pri), .pw(pw), .rx_dly(rx_dly), .rx_len(rx_len),
      .busy(busy), .pulse_sof(pulse_sof), .tx_en(tx_en),
      .wave_addr(wave_addr), .rx_en(rx_en), .rx_idx(rx_idx),
      .pulse_cnt(pulse_cnt), .cfg_err(cfg_err), .sleep_dac(sleep_dac)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got %0h exp %0h", tag, $time, got, exp);
      end
   endtask

   function automatic bit cfg_valid();
      int p = int'(pri);
      int w = int'(pw);
      int d = int'(rx_dly);
      int l = int'(rx_len);
      return p >= 2 && w >= 1 && w <= p && l >= 1 && d + l <= p;
   endfunction

   task automatic model_reset();
      ph = 0; mt = 0; mw = 0; msp = 0; mcnt = 0; merr = 0;
   endtask

   task automatic begin_pri();
      mp = int'(pri); mpw = int'(pw); md = int'(rx_dly); ml = int'(rx_len);
      ph = 2; mt = 0;
      if (mcnt < 65535) mcnt++;
   endtask

   task automatic end_period(input bit sp);
      msp = 0;
      if (sp) ph = 0;
      else if (cfg_valid()) begin_pri();
      else begin ph = 0; merr = 1; end
   endtask

   task automatic model_step();
      bit sp;
      sp = msp || stop;
      case (ph)
         0: if (start && !stop) begin
               if (cfg_valid()) begin
                  mcnt = 0; merr = 0; msp = 0;
`ifdef DAC_SLEEP_EN
                  ph = 1; mw = WAKE;
`else
                  begin_pri();
`endif
               end else merr = 1;
            end
         1: if (mw == 1) end_period(sp);
            else begin mw--; msp = sp; end
         default: if (mt == mp - 1) end_period(sp);
            else begin mt++; msp = sp; end
      endcase
   endtask

   task automatic compare_all();
      bit run, tx, rx, slp;
      run = (ph == 2);
      tx  = run && mt < mpw;
      rx  = run && mt >= md && mt < md + ml;
`ifdef DAC_SLEEP_EN
      slp = (ph == 0) || (run && mt >= mpw && (mp - 1 - mt) >= WAKE);
`else
      slp = 0;
`endif
      chk("busy", busy, ph != 0);
      chk("sof", pulse_sof, run && mt == 0);
      chk("tx_en", tx_en, tx);
      chk("wave_addr", wave_addr, tx ? (mt % (1 << ADDR_W)) : 0);
      chk("rx_en", rx_en, rx);
      chk("rx_idx", rx_idx, rx ? mt - md : 0);
      chk("pulse_cnt", pulse_cnt, mcnt);
      chk("cfg_err", cfg_err, merr);
      chk("sleep_dac", sleep_dac, slp);
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
      compare_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; tick(); stop = 1'b0;
   endtask

   task automatic wait_t(input int tt, input int budget);
      int n = 0;
      while (!(ph == 2 && mt == tt) && n < budget) begin
         tick(); n++;
      end
      if (n >= budget) begin
         checks++; errors++;
         $display("FAIL wait_t timeout waiting for t=%0d", tt);
      end
   endtask

   task automatic async_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      ticks(2);
      rst_n = 1'b1;
   endtask

   task automatic set_cfg(input int p, input int w, input int d, input int l);
      pri = 16'(p); pw = 16'(w); rx_dly = 16'(d); rx_len = 16'(l);
   endtask

   task automatic rand_cfg();
      int p;
      p = int'($urandom_range(0, 24));
      pri = 16'(p);
      pw = 16'($urandom_range(0, p + 1));
      rx_dly = 16'($urandom_range(0, p));
      rx_len = 16'($urandom_range(0, p + 1 - int'(rx_dly)));
   endtask

   initial begin
      model_reset();
      mp = 0; mpw = 0; md = 0; ml = 0;
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      rst_n = 1'b1;
      ticks(3);

      set_cfg(20, 5, 8, 6);
      pulse_start();
      ticks(70);
      wait_t(7, 40);
      pulse_stop();
      ticks(25);
      chk("idle_after_stop", busy, 1'b0);

      set_cfg(20, 0, 8, 6);
      pulse_start();
      ticks(5);
      set_cfg(20, 5, 15, 6);
      pulse_start();
      ticks(5);
      set_cfg(20, 5, 16'hFFF0, 16'h0020);
      pulse_start();
      ticks(5);
      chk("cfg_err_sticky", cfg_err, 1'b1);
      set_cfg(20, 5, 8, 6);
      pulse_start();
      ticks(30);

      wait_t(3, 40);
      pri = 16'd10;
      ticks(40);
      pw = 16'd0;
      ticks(15);
      chk("invalid_wrap_idle", busy, 1'b0);

      set_cfg(20, 5, 8, 6);
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      ticks(5);

      pulse_start();
      wait_t(2, 40);
      async_reset();
      ticks(10);

      set_cfg(1100, 1050, 0, 1100);
      pulse_start();
      ticks(1105);
      pulse_stop();
      ticks(1200);

      async_reset();
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 59) == 0) rand_cfg();
         start = ($urandom_range(0, 15) == 0);
         stop = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 799) == 0) begin
            start = 1'b0; stop = 1'b0;
            async_reset();
         end else begin
            tick();
         end
         start = 1'b0; stop = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
